// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 2-flop input synchroniser, 3-sample majority
// vote per bit, optional odd/even parity, 1 or 2 stop bits, and parity,
// framing and break detection. The frame completes at the decision point
// of the last stop bit, so the second half of that bit is spent in IDLE.
// Back-to-back frames are therefore accepted.
module uart_rx_cfg #(
    parameter int CLKS_PER_BIT = 217,  // >= 4
    parameter int DATA_BITS    = 8,    // 5..9
    parameter int PARITY       = 0,    // 0 none, 1 odd, 2 even
    parameter int STOP_BITS    = 1     // 1 or 2
) (
    input  logic                 i_Clock,
    input  logic                 i_Rst_n,
    input  logic                 i_RX_Serial,
    output logic                 o_RX_DV,
    output logic [DATA_BITS-1:0] o_RX_Byte,
    output logic                 o_Parity_Err,
    output logic                 o_Frame_Err,
    output logic                 o_Break,
    output logic                 o_RX_Busy
);

    localparam int CW  = $clog2(CLKS_PER_BIT);
    localparam int BW  = $clog2(DATA_BITS);
    localparam int MID = CLKS_PER_BIT / 2;

    localparam logic [CW-1:0] SMP_A    = CW'(MID - 1);
    localparam logic [CW-1:0] SMP_B    = CW'(MID);
    localparam logic [CW-1:0] DECIDE   = CW'(MID + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
    localparam logic          TWO_STOP = (STOP_BITS == 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP,
        S_BRK_WAIT
    } state_e;

    logic                 sync1_q, s_q;
    state_e               state_q;
    logic [CW-1:0]        cnt_q;
    logic [CW-1:0]        cnt_d;
    logic [BW-1:0]        bit_q;
    logic                 stop_idx_q;
    logic [1:0]           smp_q;
    logic [DATA_BITS-1:0] shreg_q;
    logic                 par_q;
    logic                 stop0_q;
    logic                 ferr_q;

    logic                 dv_q, perr_q, fe_q, brk_q, busy_q;
    logic [DATA_BITS-1:0] byte_q;

    logic maj, decide, wrap;
    logic perr_d, ferr_d, brk_d, first_stop;

    // Two-flop synchroniser; idle-high line resets to 1 so reset is not a start.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            sync1_q <= 1'b1;
            s_q     <= 1'b1;
        end else begin
            sync1_q <= i_RX_Serial;
            s_q     <= sync1_q;
        end
    end

    // First two of the three votes; the third is the live line at DECIDE.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            smp_q <= 2'b11;
        end else begin
            if (cnt_q == SMP_A) smp_q[0] <= s_q;
            if (cnt_q == SMP_B) smp_q[1] <= s_q;
        end
    end

    // Majority vote, bit-timing strobes and frame-end status.
    always_comb begin
        maj        = (smp_q[0] & smp_q[1]) | (smp_q[0] & s_q) | (smp_q[1] & s_q);
        decide     = (cnt_q == DECIDE);
        wrap       = (cnt_q == CNT_LAST);
        cnt_d      = wrap ? '0 : cnt_q + 1'b1;
        ferr_d     = ferr_q | ~maj;
        first_stop = TWO_STOP ? stop0_q : maj;
        perr_d     = 1'b0;
        if (PARITY == 1) perr_d = ~(^shreg_q ^ par_q);
        if (PARITY == 2) perr_d = ^shreg_q ^ par_q;
        brk_d      = (shreg_q == '0) && ((PARITY == 0) || !par_q) && !first_stop;
    end

    // Receive FSM: bit counter, shift register, error tracking and outputs.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            stop_idx_q <= 1'b0;
            shreg_q    <= '0;
            par_q      <= 1'b0;
            stop0_q    <= 1'b1;
            ferr_q     <= 1'b0;
            dv_q       <= 1'b0;
            byte_q     <= '0;
            perr_q     <= 1'b0;
            fe_q       <= 1'b0;
            brk_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            dv_q  <= 1'b0;
            brk_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (!s_q) begin
                        state_q    <= S_START;
                        busy_q     <= 1'b1;
                        bit_q      <= '0;
                        stop_idx_q <= 1'b0;
                        ferr_q     <= 1'b0;
                    end
                end
                S_START: begin
                    cnt_q <= cnt_d;
                    if (decide && maj) begin
                        // Start bit did not hold low: treat as a glitch.
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else if (wrap) begin
                        state_q <= S_DATA;
                    end
                end
                S_DATA: begin
                    cnt_q <= cnt_d;
                    if (decide) shreg_q <= {maj, shreg_q[DATA_BITS-1:1]};
                    if (wrap) begin
                        if (bit_q == BIT_LAST)
                            state_q <= (PARITY != 0) ? S_PAR : S_STOP;
                        else
                            bit_q <= bit_q + 1'b1;
                    end
                end
                S_PAR: begin
                    cnt_q <= cnt_d;
                    if (decide) par_q <= maj;
                    if (wrap) state_q <= S_STOP;
                end
                S_STOP: begin
                    cnt_q <= cnt_d;
                    if (decide) begin
                        if (!stop_idx_q) stop0_q <= maj;
                        if (!maj) ferr_q <= 1'b1;
                        if (stop_idx_q == TWO_STOP) begin
                            // Last stop bit decided: publish the frame now.
                            dv_q   <= 1'b1;
                            byte_q <= shreg_q;
                            perr_q <= perr_d;
                            fe_q   <= ferr_d;
                            brk_q  <= brk_d;
                            cnt_q  <= '0;
                            if (brk_d) begin
                                state_q <= S_BRK_WAIT;
                            end else begin
                                state_q <= S_IDLE;
                                busy_q  <= 1'b0;
                            end
                        end
                    end else if (wrap) begin
                        stop_idx_q <= 1'b1;
                    end
                end
                S_BRK_WAIT: begin
                    // Hold off start detection until the line returns high.
                    cnt_q <= '0;
                    if (s_q) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign o_RX_DV      = dv_q;
    assign o_RX_Byte    = byte_q;
    assign o_Parity_Err = perr_q;
    assign o_Frame_Err  = fe_q;
    assign o_Break      = brk_q;
    assign o_RX_Busy    = busy_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: three configurations (8N1 @217, 8E1 @20, 7O2 @13)
// driven in parallel. Each frame's expected result is derived from the bits
// put on the line and queued; a negedge monitor pops on every DV.
module tb_uart_rx_cfg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [2:0] line;
    logic [2:0] rst_n;
    logic [2:0] dv, pe, fe, brk, busy;
    logic [7:0] byte0, byte1;
    logic [6:0] byte2;

    int CPB [3] = '{217, 20, 13};
    int DB  [3] = '{8, 8, 7};
    int PARM[3] = '{0, 2, 1};
    int SB  [3] = '{1, 1, 2};

    typedef struct {
        logic [8:0] b;
        logic       pe;
        logic       fe;
        logic       br;
    } exp_t;

    exp_t sbq[3][$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   dv_cyc[3] = '{-1, -1, -1};
    int   st_cyc[3] = '{0, 0, 0};

    uart_rx_cfg u0 (
        .i_Clock(clk), .i_Rst_n(rst_n[0]), .i_RX_Serial(line[0]),
        .o_RX_DV(dv[0]), .o_RX_Byte(byte0), .o_Parity_Err(pe[0]),
        .o_Frame_Err(fe[0]), .o_Break(brk[0]), .o_RX_Busy(busy[0]));

    uart_rx_cfg #(.CLKS_PER_BIT(20), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u1 (
        .i_Clock(clk), .i_Rst_n(rst_n[1]), .i_RX_Serial(line[1]),
        .o_RX_DV(dv[1]), .o_RX_Byte(byte1), .o_Parity_Err(pe[1]),
        .o_Frame_Err(fe[1]), .o_Break(brk[1]), .o_RX_Busy(busy[1]));

    uart_rx_cfg #(.CLKS_PER_BIT(13), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u2 (
        .i_Clock(clk), .i_Rst_n(rst_n[2]), .i_RX_Serial(line[2]),
        .o_RX_DV(dv[2]), .o_RX_Byte(byte2), .o_Parity_Err(pe[2]),
        .o_Frame_Err(fe[2]), .o_Break(brk[2]), .o_RX_Busy(busy[2]));

    function automatic logic [8:0] rx_byte(input int k);
        case (k)
            0:       return {1'b0, byte0};
            1:       return {1'b0, byte1};
            default: return {2'b00, byte2};
        endcase
    endfunction

    task automatic chk(input string nm, input int k, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s u%0d: got %h want %h (t=%0t)", nm, k, got, exp, $time);
        end
    endtask

    // Reference: what a receiver must report for a frame with these line bits.
    function automatic exp_t model(input int k, input logic [8:0] data,
                                   input logic pbit, input logic [1:0] stops);
        exp_t e;
        int   ones;
        ones = $countones(data);
        e.b  = data;
        e.pe = 1'b0;
        if (PARM[k] == 1) e.pe = ((ones + int'(pbit)) % 2) != 1;
        if (PARM[k] == 2) e.pe = ((ones + int'(pbit)) % 2) != 0;
        e.fe = !stops[0] || (SB[k] == 2 && !stops[1]);
        e.br = (data == 0) && (PARM[k] == 0 || !pbit) && !stops[0];
        return e;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int k, input int n);
        line[k] = 1'b1;
        tick(n);
    endtask

    // Drive one frame; glitch >= 0 inverts the line for that one cycle offset.
    task automatic send_frame(input int k, input logic [8:0] din, input bit pflip,
                              input logic [1:0] stops, input int gap_bits,
                              input int glitch);
        logic       bits[$];
        logic [8:0] data;
        logic       pbit;
        int         ones;
        data = din & ((9'h1 << DB[k]) - 9'h1);
        ones = $countones(data);
        pbit = (PARM[k] == 1) ? (ones % 2 == 0) : (ones % 2 == 1);
        if (pflip) pbit = ~pbit;
        bits.push_back(1'b0);
        for (int i = 0; i < DB[k]; i++) bits.push_back(data[i]);
        if (PARM[k] != 0) bits.push_back(pbit);
        for (int i = 0; i < SB[k]; i++) bits.push_back(stops[i]);
        sbq[k].push_back(model(k, data, pbit, stops));
        st_cyc[k] = cyc;
        for (int c = 0; c < bits.size() * CPB[k]; c++) begin
            line[k] = bits[c / CPB[k]] ^ (c == glitch);
            tick(1);
        end
        idle(k, gap_bits * CPB[k]);
    endtask

    task automatic send_random(input int k, input int n);
        logic [8:0] d;
        logic [1:0] st;
        bit         pf;
        int         gap;
        for (int i = 0; i < n; i++) begin
            d   = 9'($urandom_range(0, 511));
            if ($urandom_range(0, 7) == 0) d = '0;
            pf  = (PARM[k] != 0) && ($urandom_range(0, 3) == 0);
            st  = 2'b11;
            gap = $urandom_range(0, 1);
            if ($urandom_range(0, 5) == 0) begin
                st  = 2'($urandom_range(0, 2));
                gap = 2;
            end
            send_frame(k, d, pf, st, gap, -1);
        end
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin : mon
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            if (rst_n[k] && dv[k]) begin
                dv_cyc[k] = cyc;
                if (sbq[k].size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_dv u%0d: got byte %h want no frame", k, rx_byte(k));
                end else begin
                    e = sbq[k].pop_front();
                    chk("byte", k, 32'(rx_byte(k)), 32'(e.b));
                    chk("parity_err", k, 32'(pe[k]), 32'(e.pe));
                    chk("frame_err", k, 32'(fe[k]), 32'(e.fe));
                    chk("break", k, 32'(brk[k]), 32'(e.br));
                end
            end else if (rst_n[k] && brk[k]) begin
                chk("break_without_dv", k, 32'(brk[k]), 32'd0);
            end
        end
    end

    task automatic chk_quiet(input string tag, input int k);
        chk({tag, "_flags"}, k, 32'({dv[k], pe[k], fe[k], brk[k], busy[k]}), 32'd0);
        chk({tag, "_byte"}, k, 32'(rx_byte(k)), 32'd0);
    endtask

    initial begin : watchdog
        repeat (95000) @(posedge clk);
        $display("FAIL watchdog: got cycle %0d want completion before it", cyc);
        $fatal(1, "timeout");
    end

    initial begin : stim
        int lat;
        line  = '1;
        rst_n = '0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) chk_quiet("reset", k);
        @(posedge clk);
        #1;
        rst_n = '1;
        tick(5);

        fork
            begin : t0
                send_frame(0, 9'h4F, 1'b0, 2'b11, 1, -1);
                lat = dv_cyc[0] - st_cyc[0];
                n_cmp++;
                if (lat < 2064 || lat > 2066) begin
                    n_bad++;
                    $display("FAIL latency u0: got %0d cycles want 2065+/-1", lat);
                end
                send_frame(0, 9'h3C, 1'b0, 2'b10, 2, -1);
                send_frame(0, 9'h55, 1'b0, 2'b11, 1, -1);
                // One-cycle low pulse on an idle line.
                line[0] = 1'b0;
                tick(1);
                line[0] = 1'b1;
                tick(4);
                chk("glitch_busy_hi", 0, 32'(busy[0]), 32'd1);
                tick(CPB[0]);
                chk("glitch_busy_lo", 0, 32'(busy[0]), 32'd0);
                idle(0, CPB[0]);
                // Inversion at the middle sample of data bit 3.
                send_frame(0, 9'h00, 1'b0, 2'b11, 1, 4 * CPB[0] + CPB[0] / 2 + 1);
                // Break: line low for 30 bit times.
                sbq[0].push_back(model(0, 9'h000, 1'b0, 2'b00));
                line[0] = 1'b0;
                tick(20 * CPB[0]);
                chk("break_wait_busy", 0, 32'(busy[0]), 32'd1);
                tick(10 * CPB[0]);
                idle(0, 2 * CPB[0]);
                chk("break_released", 0, 32'(busy[0]), 32'd0);
                send_frame(0, 9'h12, 1'b0, 2'b11, 1, -1);
                send_random(0, 4);
            end
            begin : t1
                send_frame(1, 9'hA5, 1'b0, 2'b11, 1, -1);
                send_frame(1, 9'hA5, 1'b1, 2'b11, 1, -1);
                send_random(1, 40);
            end
            begin : t2
                send_frame(2, 9'h41, 1'b0, 2'b11, 0, -1);
                send_frame(2, 9'h7F, 1'b0, 2'b11, 1, -1);
                // Third frame aborted by reset mid-byte.
                line[2] = 1'b0;
                tick(CPB[2]);
                line[2] = 1'b1;
                tick(CPB[2]);
                line[2] = 1'b0;
                tick(CPB[2] + 3);
                rst_n[2] = 1'b0;
                tick(2);
                chk_quiet("midreset", 2);
                line[2] = 1'b1;
                tick(3);
                rst_n[2] = 1'b1;
                tick(2);
                chk_quiet("postreset", 2);
                idle(2, 2 * CPB[2]);
                send_frame(2, 9'h22, 1'b0, 2'b11, 1, -1);
                send_random(2, 40);
            end
        join

        tick(3 * CPB[0]);
        for (int k = 0; k < 3; k++) begin
            while (sbq[k].size() != 0) begin
                exp_t e;
                e = sbq[k].pop_front();
                n_cmp++;
                n_bad++;
                $display("FAIL missing_dv u%0d: got no frame want byte %h", k, e.b);
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Parametrised UART receiver and successor to the fixed 8N1 uart_rx. Adds:
- configurable data width, parity and stop-bit count
- input synchroniser
- 3-sample majority voting per bit
- parity, framing and break detection

It sits between the off-chip RX pin (or a uart_tx line in loopback benches) and byte-level consumer logic.

Parameters:
CLKS_PER_BIT, 217, clock cycles per bit (25 MHz / 115200); must be >= 4
DATA_BITS, 8, data bits per frame; legal 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, stop bits checked; legal 1 or 2

Ports:
i_Clock  in  1  system clock, all logic on rising edge
i_Rst_n  in  1  asynchronous active-low reset
i_RX_Serial  in  1  asynchronous serial line, idle high
o_RX_DV  out  1  one-cycle pulse: frame complete, o_RX_Byte and error flags valid
o_RX_Byte  out  DATA_BITS  received data, LSB = first bit on line
o_Parity_Err  out  1  parity mismatch in last frame; 0 when PARITY = 0
o_Frame_Err  out  1  a stop bit was sampled low in last frame
o_Break  out  1  one-cycle pulse on break detection
o_RX_Busy  out  1  high whenever FSM is not in IDLE

Behaviour:
- Reset (async assert, sync release): synchroniser flops = 1, FSM = IDLE, counters = 0. All outputs 0 except o_RX_Byte = 0.
- Reset mid-frame aborts the frame. No DV is produced. The receiver resumes hunting for a start bit after release.
- Synchroniser: 2 flops. All logic uses the synced line `s`.
- MID = CLKS_PER_BIT/2 (integer divide).
- Bit counter runs 0..CLKS_PER_BIT-1, then wraps to 0 and advances to the next bit. It starts at 0 on the cycle after `s` is first seen low in IDLE.
- Sampling: `s` is sampled at counts MID-1, MID and MID+1. The bit value is the majority of the 3 samples, decided at count MID+1.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK_WAIT.
  - IDLE: when `s` = 0, go to START.
  - START: majority 1 (glitch) -> IDLE with no outputs. Otherwise, at wrap -> DATA.
  - DATA: shift DATA_BITS majority values LSB-first into a shift register. After the last bit wraps: go to PARITY if PARITY != 0, else STOP.
  - PARITY: compare the sampled bit with the computed parity. Odd parity: XOR(data, parity bit) must be 1. Even parity: it must be 0. At wrap -> STOP.
  - STOP: sample STOP_BITS bits. Any majority 0 sets the frame error.
- Frame end: at MID+1 of the last stop bit (not at wrap), on the next edge:
  - o_RX_DV = 1 for exactly one cycle
  - o_RX_Byte, o_Parity_Err and o_Frame_Err load together
  - FSM -> IDLE
  - The remaining half stop bit is spent in IDLE, so back-to-back frames are accepted.
- DV asserts even when errors are flagged.
- o_RX_Byte and the error flags hold their values until the next DV. They are not cleared by a glitch start.
- Break: all data bits 0, parity bit 0 (if present) and the first stop bit 0. In that case:
  - o_Break pulses 1 cycle, coincident with DV; o_Frame_Err = 1
  - FSM -> BREAK_WAIT, stays while `s` = 0, and goes to IDLE on the first cycle `s` = 1
  - no new start detection until then
- Single-cycle glitches exactly at a sample point are outvoted. Data or stop glitches never abort a frame.
- Latency, 8N1 defaults: DV rises 2 + 9*217 + 109 + 1 = 2065 cycles (+/-1) after the start falling edge on i_RX_Serial.
- o_RX_Busy = (FSM != IDLE), registered.

Test Plan:
- Defaults 8N1: uart_tx sends 0x4F -> one DV pulse, o_RX_Byte = 0x4F, both error flags 0, DV at 2065 +/-1 cycles from start edge.
- PARITY=2, DATA_BITS=8: send 0xA5 with correct parity 0 -> DV, Parity_Err = 0. Then send 0xA5 with parity bit forced to 1 -> DV, byte 0xA5, Parity_Err = 1.
- Defaults: send 0x3C with the stop bit driven low -> DV, byte 0x3C, Frame_Err = 1, Break = 0. Next frame 0x55 is clean -> Frame_Err returns to 0.
- Glitches, defaults:
  - 1-cycle low pulse on an idle line -> no DV, Busy returns to 0 within CLKS_PER_BIT cycles
  - 1-cycle inversion at MID of data bit 3 of 0x00 -> byte 0x00
- Hold line low for 30 bit times -> one Break pulse with DV, byte 0x00, Frame_Err = 1, FSM in BREAK_WAIT. Release line then send 0x12 -> received correctly.
- DATA_BITS=7, PARITY=1, STOP_BITS=2: back-to-back 0x41, 0x7F with no idle gap -> two DVs, correct bytes, no errors. Assert i_Rst_n mid-byte on a third frame -> no DV, all outputs 0, next frame 0x22 received.
